ex_div: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage. Consumes

---
 rtl/ex_div.sv | 152 +++++++++++++++
 tb/tb_ex_div.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the EX stage; result is {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop via the ZERO state.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_END, ST_ZERO} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   dvd_reg, dvd_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0]   dsr_reg, dsr_next;
    logic [WIDTH-1:0]   zrem_reg, zrem_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               zero_reg, zero_next;
    logic [2*WIDTH-1:0] result_reg, result_next;
    logic               ready_reg, ready_next;

    logic               neg1, neg2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     part, diff;
    logic               q_bit;
    logic [WIDTH-1:0]   q_final, r_final;
    logic [2*WIDTH-1:0] final_result;

    // Unsigned W-bit magnitude equals the low bits of the W+1-bit negation, so MIN maps to 2^(W-1).
    assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign mag1 = neg1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign mag2 = neg2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // One restoring step: quotient bits shift into the low end of the dividend register.
    assign part  = {rem_reg, dvd_reg[WIDTH-1]};
    assign diff  = part - {1'b0, dsr_reg};
    assign q_bit = ~diff[WIDTH];

    assign q_final      = neg_q_reg ? (~dvd_reg + WIDTH'(1)) : dvd_reg;
    assign r_final      = neg_r_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;
    assign final_result = zero_reg ? {zrem_reg, {WIDTH{1'b1}}} : {r_final, q_final};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            rem_reg    <= '0;
            dsr_reg    <= '0;
            zrem_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            dvd_reg    <= dvd_next;
            rem_reg    <= rem_next;
            dsr_reg    <= dsr_next;
            zrem_reg   <= zrem_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            zero_reg   <= zero_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dvd_next   = dvd_reg;
        rem_next   = rem_reg;
        dsr_next   = dsr_reg;
        zrem_next  = zrem_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        zero_next  = zero_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_next   = mag1;
                    dsr_next   = mag2;
                    rem_next   = '0;
                    cnt_next   = '0;
                    neg_q_next = neg1 ^ neg2;
                    neg_r_next = neg1;
                    zero_next  = (opdata2_i == '0);
`ifdef DIV_ZERO_FAST_EN
                    zrem_next  = '0;
                    state_next = (opdata2_i == '0) ? ST_ZERO : ST_RUN;
`else
                    zrem_next  = opdata1_i;
                    state_next = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                if (annul_i) begin
                    state_next = ST_IDLE;
                end else begin
                    rem_next = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                    dvd_next = {dvd_reg[WIDTH-2:0], q_bit};
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1))
                        state_next = ST_END;
                end
            end
            ST_END: begin
                if (ready_reg && !start_i)
                    state_next = ST_IDLE;
            end
`ifdef DIV_ZERO_FAST_EN
            ST_ZERO: state_next = ST_END;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // First END edge registers the result; it is then held until EX drops start_i.
    always_comb begin
        result_next = '0;
        ready_next  = 1'b0;
        if (state_reg == ST_END) begin
            if (!ready_reg) begin
                result_next = final_result;
                ready_next  = 1'b1;
            end else if (start_i) begin
                result_next = result_reg;
                ready_next  = 1'b1;
            end
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, results, hold/drop handshake, annul and async reset.
// Zero-divisor expectations follow DIV_ZERO_FAST_EN when the bench is built with it.
module tb_ex_div;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
    localparam bit ZFAST = 1'b1;
`else
    localparam int ZLAT = 33;
    localparam bit ZFAST = 1'b0;
`endif
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_div = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        @(posedge clk); #1;
    endtask

    // Scrambles the operand inputs after capture, then counts edges until ready (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        op1 = $urandom; op2 = $urandom; signed_div = ~signed_div;
        while (!ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [63:0] exp, input int lat);
        int n;
        launch(s, a, b);
        check({tag, " busy"}, {63'b0, ready}, 64'd0);
        wait_ready(n);
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result, exp);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        check({tag, " hold ready"}, {63'b0, ready}, 64'd1);
        check({tag, " hold result"}, result, exp);
        @(negedge clk); annul = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop ready"}, {63'b0, ready}, 64'd0);
        check({tag, " drop result"}, result, 64'd0);
        $display("div %s: signed=%0b %h / %h -> %h after %0d edges", tag, s, a, b, exp, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {63'b0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk); rst = 1'b1;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, LAT);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, LAT);
        run_div("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, LAT);
        run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE}, LAT);
        run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, LAT);
        run_div("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, LAT);
        run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, LAT);
        run_div("divu 5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, LAT);
        run_div("divu x/0", 1'b0, 32'h1234_5678, 32'h0,
                {(ZFAST ? 32'h0 : 32'h1234_5678), 32'hFFFF_FFFF}, ZLAT);
        run_div("div -7/0", 1'b1, 32'hFFFF_FFF9, 32'h0,
                {(ZFAST ? 32'h0 : 32'hFFFF_FFF9), 32'hFFFF_FFFF}, ZLAT);

        // Annul at the tenth RUN edge, then restart at once.
        launch(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk); annul = 1'b1;
        @(posedge clk); #1;
        check("annul ready", {63'b0, ready}, 64'd0);
        check("annul result", result, 64'd0);
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, LAT);

        // Asynchronous reset between edges mid-RUN.
        launch(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("arst run ready", {63'b0, ready}, 64'd0);
        check("arst run result", result, 64'd0);
        @(negedge clk); rst = 1'b1; start = 1'b0;
        run_div("divu 15/4", 1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, LAT);

        // Asynchronous reset while a result is being held.
        launch(1'b0, 32'd100, 32'd7);
        begin
            int n;
            wait_ready(n);
            check("arst end latency", 64'(n), 64'(LAT));
        end
        #3 rst = 1'b0;
        #1;
        check("arst end ready", {63'b0, ready}, 64'd0);
        check("arst end result", result, 64'd0);
        @(negedge clk); rst = 1'b1; start = 1'b0;
        run_div("divu 100/7 again", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
